// File: rtl/ldl_round_pkg.sv
// Shared types and helpers for the class-priority round-robin arbiters.
package ldl_round_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int RR_MAX = 32;

    // Index of the first set bit of vec[n-1:0] searching ptr+1, ptr+2, ... with wrap at n; -1 if none.
    function automatic int rr_first(input logic [RR_MAX-1:0] vec, input int ptr, input int n);
        int idx;
        rr_first = -1;
        for (int k = n; k >= 1; k--) begin
            idx = (ptr + k) % n;
            if (vec[idx]) rr_first = idx;
        end
    endfunction

endpackage

// File: rtl/ldl_round_pri_lock_if.sv
// Request/grant bundle between requesters and the class-priority lock arbiter.
interface ldl_round_pri_lock_if #(
    parameter int REQ_NUM   = 5,
    parameter int COS_WIDTH = 2,
    parameter int BIN_WIDTH = $clog2(REQ_NUM)
);
    // Handshake: a grant is offered only in a cycle where en=1; ack pulses for one cycle when
    // the new owner is presented, gnt_vld/hot hold until done[bin] or req[bin] drops.
    logic                                en;
    logic [REQ_NUM-1:0]                  req;
    logic [REQ_NUM-1:0][COS_WIDTH-1:0]   cos;
    logic [REQ_NUM-1:0]                  done;
    logic                                ack;
    logic                                gnt_vld;
    logic [REQ_NUM-1:0]                  hot;
    logic [BIN_WIDTH-1:0]                bin;
    logic [BIN_WIDTH-1:0]                pre_bin;
    logic                                aged;

    modport master (
        output en, req, cos, done,
        input  ack, gnt_vld, hot, bin, pre_bin, aged
    );

    modport slave (
        input  en, req, cos, done,
        output ack, gnt_vld, hot, bin, pre_bin, aged
    );
endinterface

// File: rtl/ldl_rr_pick.sv
// Combinational round-robin pick: first set bit of vec after ptr, wrapping at N.
module ldl_rr_pick #(
    parameter int N = 5,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);
    localparam int PW = $clog2(2 * N);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;
    logic [PW-1:0]  pos;

    // Doubling the vector turns the wrap into a plain window [ptr+1, ptr+N].
    always_comb begin
        dbl    = {vec, vec};
        masked = '0;
        for (int j = 0; j < 2 * N; j++) begin
            if (j > int'(ptr) && j <= int'(ptr) + N) masked[j] = dbl[j];
        end
        found = 1'b0;
        pos   = '0;
        for (int j = 2 * N - 1; j >= 0; j--) begin
            if (masked[j]) begin
                found = 1'b1;
                pos   = PW'(j);
            end
        end
        idx    = (int'(pos) >= N) ? W'(int'(pos) - N) : W'(pos);
        onehot = '0;
        if (found) onehot[idx] = 1'b1;
    end
endmodule

// File: rtl/ldl_round_pri_lock.sv
// Class-priority round-robin arbiter with per-requester aging and an optional grant lock.
module ldl_round_pri_lock
    import ldl_round_pkg::*;
#(
    parameter int REQ_NUM   = 5,
    parameter int BIN_WIDTH = $clog2(REQ_NUM),
    parameter int COS_WIDTH = 2,
    parameter int AGE_MAX   = 15,
    parameter int LOCK_EN   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ldl_round_pri_lock_if.slave  bus,
    output state_t               dbg_state
);
    localparam int AGE_W = $clog2(AGE_MAX + 1);
    localparam int EFF_W = COS_WIDTH + 1;
    localparam logic [AGE_W-1:0] AGE_TOP = AGE_W'(AGE_MAX);

    state_t                           state, state_nxt;
    logic [REQ_NUM-1:0][AGE_W-1:0]    age;
    logic [BIN_WIDTH-1:0]             ptr;
    logic [REQ_NUM-1:0]               promo, cand, win_hot;
    logic [REQ_NUM-1:0][EFF_W-1:0]    eff;
    logic [EFF_W-1:0]                 max_eff;
    logic                             win_found, arb, rel;
    logic [BIN_WIDTH-1:0]             win_idx;

    logic                             ack_q, gnt_q, aged_q;
    logic [REQ_NUM-1:0]               hot_q;
    logic [BIN_WIDTH-1:0]             bin_q, pre_q;

    // A saturated age becomes the top bit of the effective class, outranking any cos.
    always_comb begin
        promo   = '0;
        eff     = '0;
        cand    = '0;
        max_eff = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            promo[i] = (age[i] == AGE_TOP);
            eff[i]   = {promo[i], bus.cos[i]};
            if (bus.req[i] && eff[i] > max_eff) max_eff = eff[i];
        end
        for (int i = 0; i < REQ_NUM; i++) begin
            cand[i] = bus.req[i] && (eff[i] == max_eff);
        end
    end

    ldl_rr_pick #(.N(REQ_NUM), .W(BIN_WIDTH)) u_pick (
        .vec    (cand),
        .ptr    (ptr),
        .found  (win_found),
        .idx    (win_idx),
        .onehot (win_hot)
    );

    assign arb = (state == IDLE) && bus.en && win_found;
    assign rel = (state == BUSY) && (bus.done[bin_q] || !bus.req[bin_q]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb && LOCK_EN != 0) state_nxt = BUSY;
            BUSY:    if (rel) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= BIN_WIDTH'(REQ_NUM - 1);
            ack_q  <= 1'b0;
            gnt_q  <= 1'b0;
            aged_q <= 1'b0;
            hot_q  <= '0;
            bin_q  <= '0;
            pre_q  <= '0;
        end else begin
            state <= state_nxt;
            ack_q <= arb;
            if (arb) begin
                hot_q  <= win_hot;
                bin_q  <= win_idx;
                pre_q  <= bin_q;
                aged_q <= promo[win_idx];
                gnt_q  <= 1'b1;
                ptr    <= win_idx;
            end else if (LOCK_EN == 0 || rel) begin
                hot_q  <= '0;
                gnt_q  <= 1'b0;
                aged_q <= 1'b0;
            end
        end
    end

    // Ages move only on arbitration cycles, except that an idle requester always forgets its wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else begin
            for (int i = 0; i < REQ_NUM; i++) begin
                if (!bus.req[i]) begin
                    age[i] <= '0;
                end else if (arb) begin
                    if (win_hot[i])            age[i] <= '0;
                    else if (age[i] != AGE_TOP) age[i] <= age[i] + AGE_W'(1);
                end
            end
        end
    end

    assign bus.ack     = ack_q;
    assign bus.gnt_vld = gnt_q;
    assign bus.hot     = hot_q;
    assign bus.bin     = bin_q;
    assign bus.pre_bin = pre_q;
    assign bus.aged    = aged_q;
    assign dbg_state   = state;
endmodule

// File: tb/tb_ldl_round_pri_lock.sv
// Directed and random checks of ldl_round_pri_lock, locked (dut0) and single-cycle (dut1) variants.
module tb_ldl_round_pri_lock;
    import ldl_round_pkg::*;

    localparam int N        = 5;
    localparam int CW       = 2;
    localparam int BW       = 3;
    localparam int AGE_MAX  = 3;
    localparam int WAIT_MAX = (AGE_MAX + 1) * N;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ldl_round_pri_lock_if #(.REQ_NUM(N), .COS_WIDTH(CW), .BIN_WIDTH(BW)) bus0 ();
    ldl_round_pri_lock_if #(.REQ_NUM(N), .COS_WIDTH(CW), .BIN_WIDTH(BW)) bus1 ();
    state_t st0, st1;

    logic         auto_done;
    logic [N-1:0] manual_done;
    assign bus0.done = auto_done ? (bus0.ack ? bus0.hot : '0) : manual_done;

    ldl_round_pri_lock #(.REQ_NUM(N), .BIN_WIDTH(BW), .COS_WIDTH(CW), .AGE_MAX(AGE_MAX), .LOCK_EN(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .dbg_state(st0));
    ldl_round_pri_lock #(.REQ_NUM(N), .BIN_WIDTH(BW), .COS_WIDTH(CW), .AGE_MAX(AGE_MAX), .LOCK_EN(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(st1));

    // scoreboard
    int n_cmp = 0;
    int n_bad = 0;
    logic [6:0] exp0_q[$];
    logic [6:0] exp1_q[$];
    logic sb_on  = 1'b1;
    logic sb1_on = 1'b0;
    int waitc[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ent(input int b, input int p, input bit a);
        return {a, 3'(b), 3'(p)};
    endfunction

    always @(negedge clk) begin
        if (sb_on && bus0.ack) begin
            if (exp0_q.size() == 0) chk("dut0_unexpected_ack", 32'(bus0.ack), 32'd0);
            else chk("dut0_grant", 32'({bus0.aged, bus0.bin, bus0.pre_bin}), 32'(exp0_q.pop_front()));
        end
        if (sb1_on) begin
            chk("dut1_ack_eq_gnt", 32'(bus1.ack), 32'(bus1.gnt_vld));
            if (bus1.ack) begin
                if (exp1_q.size() == 0) chk("dut1_unexpected_ack", 32'(bus1.ack), 32'd0);
                else chk("dut1_grant", 32'({bus1.aged, bus1.bin, bus1.pre_bin}), 32'(exp1_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic wait_acks0(input int n, input int budget, input string name);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus0.ack) seen++;
        end
        chk(name, 32'(seen), 32'(n));
    endtask

    task automatic drain0(input string name);
        repeat (3) @(negedge clk);
        chk(name, 32'(exp0_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int worst;
        bus0.en = 1'b0; bus0.req = '0; bus0.cos = '0;
        bus1.en = 1'b0; bus1.req = '0; bus1.cos = '0; bus1.done = '0;
        auto_done = 1'b1; manual_done = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(bus0.ack), 32'd0);
        chk("rst_gnt_vld", 32'(bus0.gnt_vld), 32'd0);
        chk("rst_hot", 32'(bus0.hot), 32'd0);
        chk("rst_bin", 32'(bus0.bin), 32'd0);
        chk("rst_pre_bin", 32'(bus0.pre_bin), 32'd0);
        chk("rst_aged", 32'(bus0.aged), 32'd0);
        chk("rst_state", 32'(st0), 32'(IDLE));
        chk("rst_dut1_gnt", 32'(bus1.gnt_vld), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: all request, equal class; ages promote the later ones but order stays 0..4,0
        bus0.en = 1'b1;
        exp0_q.push_back(ent(0, 0, 0));
        exp0_q.push_back(ent(1, 0, 0));
        exp0_q.push_back(ent(2, 1, 0));
        exp0_q.push_back(ent(3, 2, 1));
        exp0_q.push_back(ent(4, 3, 1));
        exp0_q.push_back(ent(0, 4, 1));
        bus0.req = 5'b11111;
        wait_acks0(6, 100, "t1_acks");
        bus0.req = '0;
        drain0("t1_drain");

        // 2: class 3 requester starves class 0 until its age saturates
        bus0.cos = '0;
        bus0.cos[4] = 2'd3;
        exp0_q.push_back(ent(4, 0, 0));
        exp0_q.push_back(ent(4, 4, 0));
        exp0_q.push_back(ent(4, 4, 0));
        exp0_q.push_back(ent(1, 4, 1));
        exp0_q.push_back(ent(4, 1, 0));
        exp0_q.push_back(ent(4, 4, 0));
        exp0_q.push_back(ent(4, 4, 0));
        bus0.req = 5'b10010;
        wait_acks0(7, 100, "t2_acks");
        bus0.req = '0;
        drain0("t2_drain");

        // 3: lock held without done, others ignored, release on req drop, one bubble
        bus0.cos = '0;
        auto_done = 1'b0;
        exp0_q.push_back(ent(2, 4, 0));
        bus0.req = 5'b00100;
        wait_acks0(1, 20, "t3_ack");
        bus0.req = 5'b11111;
        manual_done = 5'b11011;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_hold_gnt", 32'(bus0.gnt_vld), 32'd1);
            chk("t3_hold_hot", 32'(bus0.hot), 32'b00100);
        end
        exp0_q.push_back(ent(3, 2, 0));
        bus0.req = 5'b11011;
        manual_done = '0;
        @(negedge clk);
        chk("t3_release_gnt", 32'(bus0.gnt_vld), 32'd0);
        chk("t3_bubble_ack", 32'(bus0.ack), 32'd0);
        @(negedge clk);
        chk("t3_regrant_ack", 32'(bus0.ack), 32'd1);
        auto_done = 1'b1;
        bus0.req = '0;
        drain0("t3_drain");

        // 4: single-cycle grants alternate; en=0 freezes ptr and ages
        sb1_on = 1'b1;
        exp1_q.push_back(ent(0, 0, 0));
        exp1_q.push_back(ent(4, 0, 0));
        exp1_q.push_back(ent(0, 4, 0));
        exp1_q.push_back(ent(4, 0, 0));
        bus1.en = 1'b1;
        bus1.req = 5'b10001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_ack_on", 32'(bus1.ack), 32'd1);
        end
        bus1.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_ack_frozen", 32'(bus1.ack), 32'd0);
        end
        exp1_q.push_back(ent(0, 4, 0));
        exp1_q.push_back(ent(4, 0, 0));
        bus1.en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t4_ack_resume", 32'(bus1.ack), 32'd1);
        end
        bus1.req = '0;
        @(negedge clk);
        chk("t4_idle_gnt", 32'(bus1.gnt_vld), 32'd0);
        sb1_on = 1'b0;
        chk("t4_drain", 32'(exp1_q.size()), 32'd0);

        // 5: reset while busy with bin 3
        auto_done = 1'b0;
        exp0_q.push_back(ent(3, 3, 0));
        bus0.req = 5'b01000;
        wait_acks0(1, 20, "t5_ack");
        repeat (2) @(negedge clk);
        chk("t5_busy_bin", 32'(bus0.bin), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_ack", 32'(bus0.ack), 32'd0);
        chk("t5_rst_gnt", 32'(bus0.gnt_vld), 32'd0);
        chk("t5_rst_hot", 32'(bus0.hot), 32'd0);
        chk("t5_rst_bin", 32'(bus0.bin), 32'd0);
        chk("t5_rst_pre", 32'(bus0.pre_bin), 32'd0);
        chk("t5_rst_aged", 32'(bus0.aged), 32'd0);
        repeat (2) @(negedge clk);
        exp0_q.push_back(ent(3, 0, 0));
        rst_n = 1'b1;
        wait_acks0(1, 20, "t5_post_ack");
        auto_done = 1'b1;
        bus0.req = '0;
        drain0("t5_drain");

        // 6: random traffic, structural invariants and bounded waiting
        sb_on = 1'b0;
        auto_done = 1'b0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("t6_onehot", 32'((bus0.hot & (bus0.hot - 5'd1)) == 5'd0), 32'd1);
            if (bus0.gnt_vld) chk("t6_hot_bin", 32'(bus0.hot), 32'd1 << bus0.bin);
            else chk("t6_hot_idle", 32'(bus0.hot), 32'd0);
            for (int i = 0; i < N; i++) if (!bus0.req[i]) waitc[i] = 0;
            if (bus0.ack) begin
                worst = 0;
                for (int i = 0; i < N; i++) begin
                    if (i == int'(bus0.bin)) waitc[i] = 0;
                    else if (bus0.req[i]) waitc[i]++;
                    if (waitc[i] > worst) worst = waitc[i];
                end
                chk("t6_starve", 32'(worst > WAIT_MAX), 32'd0);
            end
            if ($urandom_range(3) == 0) bus0.req = 5'($urandom_range(31));
            if ($urandom_range(7) == 0) bus0.cos = 10'($urandom_range(1023));
            bus0.en = ($urandom_range(3) != 0);
            manual_done = ($urandom_range(5) == 0) ? 5'($urandom_range(31)) : 5'd0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
